// File: rtl/npc_seq_ctrl_pkg.sv
// Shared types and defaults for the NPC multi-cycle sequencer.
package npc_seq_ctrl_pkg;

  localparam int unsigned    XLEN_DEF     = 64;
  localparam int unsigned    INST_W_DEF   = 32;
  localparam logic [63:0]    RESET_PC_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/npc_perf_cnt.sv
// Cycle and retired-instruction counters for the simulation environment.
module npc_perf_cnt #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            count_en,
  input  logic            retire,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  logic [XLEN-1:0] cycle_q, cycle_d;
  logic [XLEN-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (count_en) cycle_d = cycle_q + XLEN'(1);
    if (retire)   instret_d = instret_q + XLEN'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: rtl/npc_seq_ctrl.sv
// NPC sequencer: fetch over valid/ready, hold inst for the decoder, execute
// addi/ebreak, halt on ebreak or unrecognised instruction.
module npc_seq_ctrl
  import npc_seq_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     INST_W   = INST_W_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic [INST_W-1:0] inst,
  input  logic              dec_addi,
  input  logic              dec_ebreak,
  input  logic [XLEN-1:0]   a0_val,
  output logic              rf_wen,
  output logic [XLEN-1:0]   pc,
  output logic              halted,
  output logic              halt_good,
  output logic              halt_illegal,
  output logic [XLEN-1:0]   cycle_cnt,
  output logic [XLEN-1:0]   instret_cnt
);

  state_t              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                halted_q, halted_d;
  logic                halt_good_q, halt_good_d;
  logic                halt_illegal_q, halt_illegal_d;
  logic                count_en;
  logic                retire;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    halted_d       = halted_q;
    halt_good_d    = halt_good_q;
    halt_illegal_d = halt_illegal_q;
    imem_req_valid = 1'b0;
    rf_wen         = 1'b0;
    retire         = 1'b0;
    count_en       = (state_q != ST_HALT);

    unique case (state_q)
      ST_FETCH: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ebreak wins if the decoder ever flags both
        if (dec_ebreak) begin
          halted_d    = 1'b1;
          halt_good_d = (a0_val == '0);
          retire      = 1'b1;
          state_d     = ST_HALT;
        end else if (dec_addi) begin
          rf_wen  = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          halted_d       = 1'b1;
          halt_illegal_d = 1'b1;
          halt_good_d    = 1'b0;
          state_d        = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FETCH;
      pc_q           <= RESET_PC;
      inst_q         <= '0;
      halted_q       <= 1'b0;
      halt_good_q    <= 1'b0;
      halt_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      halted_q       <= halted_d;
      halt_good_q    <= halt_good_d;
      halt_illegal_q <= halt_illegal_d;
    end
  end

  npc_perf_cnt #(
    .XLEN(XLEN)
  ) u_perf_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_en   (count_en),
    .retire     (retire),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign halted       = halted_q;
  assign halt_good    = halt_good_q;
  assign halt_illegal = halt_illegal_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed bench for npc_seq_ctrl; a second instance covers PC wrap-around.
module tb_npc_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [63:0] a0_val;
  logic        dec_addi;
  logic        dec_ebreak;

  logic        imem_req_valid, rf_wen, halted, halt_good, halt_illegal;
  logic [63:0] imem_addr, pc, cycle_cnt, instret_cnt;
  logic [31:0] inst;

  logic        w_req_valid, w_rf_wen, w_halted, w_halt_good, w_halt_illegal;
  logic [63:0] w_imem_addr, w_pc, w_cycle_cnt, w_instret_cnt;
  logic [31:0] w_inst;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [31:0] ADDI   = 32'h0050_0093;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ILLEG  = 32'hFFFF_FFFF;
  localparam logic [63:0] RPC    = 64'h8000_0000;

  // minimal decoder standing in for the real one
  assign dec_addi   = (inst[6:0] == 7'h13) && (inst[14:12] == 3'b000);
  assign dec_ebreak = (inst == EBREAK);

  npc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst(inst),
    .dec_addi(dec_addi), .dec_ebreak(dec_ebreak), .a0_val(a0_val),
    .rf_wen(rf_wen), .pc(pc), .halted(halted), .halt_good(halt_good),
    .halt_illegal(halt_illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  npc_seq_ctrl #(
    .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(w_imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst(w_inst),
    .dec_addi(dec_addi), .dec_ebreak(dec_ebreak), .a0_val(a0_val),
    .rf_wen(w_rf_wen), .pc(w_pc), .halted(w_halted), .halt_good(w_halt_good),
    .halt_illegal(w_halt_illegal), .cycle_cnt(w_cycle_cnt), .instret_cnt(w_instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    a0_val         = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge after EXEC.
  task automatic run_inst(input logic [31:0] word, input logic [63:0] a0,
                          input logic exp_wen, input string tag);
    imem_req_ready = 1'b1;
    @(negedge clk);
    check({tag, "_wait_wen"}, 64'(rf_wen), 64'(0));
    check({tag, "_wait_req"}, 64'(imem_req_valid), 64'(0));
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    a0_val         = a0;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check({tag, "_inst"}, 64'(inst), 64'(word));
    check({tag, "_exec_wen"}, 64'(rf_wen), 64'(exp_wen));
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    a0_val         = '0;

    // reset state
    do_reset();
    check("rst_pc", pc, RPC);
    check("rst_inst", 64'(inst), 64'(0));
    check("rst_halted", 64'({halted, halt_good, halt_illegal}), 64'(0));
    check("rst_cycle", cycle_cnt, 64'(0));
    check("rst_instret", instret_cnt, 64'(0));
    check("rst_req_valid", 64'(imem_req_valid), 64'(1));
    check("rst_addr", imem_addr, RPC);
    check("rst_wen", 64'(rf_wen), 64'(0));

    // single addi at minimum latency
    run_inst(ADDI, 64'd0, 1'b1, "addi1");
    check("addi1_pc", pc, 64'h8000_0004);
    check("addi1_instret", instret_cnt, 64'd1);
    check("addi1_cycle", cycle_cnt, 64'd3);
    check("wrap_pc", w_pc, 64'd0);
    check("addi1_addr", imem_addr, 64'h8000_0004);

    // second addi then ebreak with a0 == 0
    run_inst(ADDI, 64'd0, 1'b1, "addi2");
    check("addi2_pc", pc, 64'h8000_0008);
    run_inst(EBREAK, 64'd0, 1'b0, "ebrk0");
    check("ebrk0_halted", 64'(halted), 64'(1));
    check("ebrk0_good", 64'(halt_good), 64'(1));
    check("ebrk0_illegal", 64'(halt_illegal), 64'(0));
    check("ebrk0_pc", pc, 64'h8000_0008);
    check("ebrk0_instret", instret_cnt, 64'd3);
    check("ebrk0_cycle", cycle_cnt, 64'd9);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = ADDI;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_req", 64'(imem_req_valid), 64'(0));
      check("halt_wen", 64'(rf_wen), 64'(0));
    end
    check("frozen_pc", pc, 64'h8000_0008);
    check("frozen_inst", 64'(inst), 64'(EBREAK));
    check("frozen_cycle", cycle_cnt, 64'd9);
    check("frozen_instret", instret_cnt, 64'd3);
    check("frozen_halted", 64'({halted, halt_good, halt_illegal}), 64'(3'b110));

    // request stalled for 4 cycles, then ebreak with a0 != 0
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_req", 64'(imem_req_valid), 64'(1));
      check("stall_addr", imem_addr, RPC);
    end
    check("stall_cycle", cycle_cnt, 64'd4);
    check("stall_pc", pc, RPC);
    run_inst(EBREAK, 64'd1, 1'b0, "ebrk1");
    check("ebrk1_flags", 64'({halted, halt_good, halt_illegal}), 64'(3'b100));
    check("ebrk1_instret", instret_cnt, 64'd1);

    // unrecognised instruction
    do_reset();
    run_inst(ILLEG, 64'd0, 1'b0, "illeg");
    check("illeg_flags", 64'({halted, halt_good, halt_illegal}), 64'(3'b101));
    check("illeg_instret", instret_cnt, 64'd0);
    check("illeg_pc", pc, RPC);
    @(negedge clk);
    check("illeg_wen_after", 64'(rf_wen), 64'(0));

    // asynchronous reset while a fetch is outstanding
    do_reset();
    run_inst(ADDI, 64'd0, 1'b1, "pre_rst");
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("mid_req_in_wait", 64'(imem_req_valid), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", pc, RPC);
    check("arst_inst", 64'(inst), 64'(0));
    check("arst_cycle", cycle_cnt, 64'd0);
    check("arst_instret", instret_cnt, 64'd0);
    check("arst_req", 64'(imem_req_valid), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = ADDI;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("late_rsp_inst", 64'(inst), 64'(0));
    check("late_rsp_req", 64'(imem_req_valid), 64'(1));
    check("late_rsp_addr", imem_addr, RPC);
    check("late_rsp_wen", 64'(rf_wen), 64'(0));
    check("late_rsp_cycle", cycle_cnt, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npc_seq_ctrl.md
Name: npc_seq_ctrl

Overview:
- Multi-cycle sequencer for the NPC core. It owns the PC and fetches each instruction over a valid/ready instruction-memory port, then holds the instruction stable for the combinational instruction decoder.
- It consumes the decoder's instruction-class flags (addi, ebreak) to pulse register-file write enable and advance the PC.
- It stops the core on ebreak (good/bad trap from a0) or on an unrecognised instruction (illegal halt).
- Also keeps 64-bit cycle and retired-instruction counters for the simulation environment.

Parameters:
- XLEN, 64, width of PC, a0 and counters
- INST_W, 32, instruction width
- RESET_PC, 64'h8000_0000, PC value loaded at reset

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  XLEN  fetch address, equals pc
- imem_rsp_valid  input  1  instruction data valid
- imem_rsp_data  input  INST_W  fetched instruction
- inst  output  INST_W  registered instruction driven to the decoder
- dec_addi  input  1  decoder flag: inst is addi
- dec_ebreak  input  1  decoder flag: inst is ebreak
- a0_val  input  XLEN  current value of x10, sampled on ebreak
- rf_wen  output  1  register-file write enable, one-cycle pulse
- pc  output  XLEN  architectural PC
- halted  output  1  core stopped (sticky)
- halt_good  output  1  valid when halted: ebreak with a0==0
- halt_illegal  output  1  valid when halted: unrecognised instruction
- cycle_cnt  output  XLEN  cycles since reset, stops when halted
- instret_cnt  output  XLEN  retired instructions

Behaviour:
- Reset (async assert on rst_n low, deassert synchronous to clk):
  - state=FETCH, pc=RESET_PC, inst=0.
  - rf_wen=0, halted=0, halt_good=0, halt_illegal=0, both counters=0.
- FETCH:
  - imem_req_valid=1 and imem_addr=pc, held stable until imem_req_ready=1.
  - Handshake occurs on the rising edge where valid&ready; the next state is WAIT.
  - imem_rsp_valid is ignored in FETCH.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1, inst<=imem_rsp_data and the next state is EXEC.
  - Otherwise remain in WAIT (no timeout).
- EXEC (exactly one cycle; decoder flags are valid because inst is stable):
  - addi: rf_wen=1 this cycle, pc<=pc+4 (XLEN wrap-around, no overflow flag), instret+1, next FETCH.
  - ebreak: rf_wen=0, halted<=1, halt_good<=(a0_val==0), instret+1, pc unchanged, next HALT.
  - dec_addi and dec_ebreak both 1: ebreak has priority. This is not expected from the decoder but is defined here.
  - Neither flag set: halted<=1, halt_illegal<=1, halt_good<=0, instret unchanged, next HALT.
- HALT:
  - Absorbing state; leaves only via rst_n.
  - All request and write outputs are 0; pc, inst and counters are frozen.
- rf_wen is combinational from (state==EXEC & dec_addi & ~dec_ebreak). It is never 1 outside EXEC.
- cycle_cnt increments every clock while state!=HALT, including the cycle that enters HALT. It wraps at 2^XLEN.
- Minimum latency per instruction is 3 cycles (FETCH with ready=1, WAIT with rsp_valid=1, EXEC).
- Reset mid-operation (any state, including during an outstanding request) returns everything to reset values immediately. A late imem_rsp_valid arriving in FETCH after reset is ignored.
- Outputs pc, inst, halted, halt_good, halt_illegal and the counters are all registered.

Decomposition:
- Shared defines header additions:
  - State encoding constants ST_FETCH=2'd0, ST_WAIT=2'd1, ST_EXEC=2'd2, ST_HALT=2'd3.
  - RESET_PC default; XLEN/InstWidth reuse the existing width macros.
- One sub-module: npc_perf_cnt. It holds the two counters, with inputs count_en and retire and outputs cycle_cnt and instret_cnt.
- The FSM and PC stay in the top.

Test Plan:
- Reset then ready=1, rsp_valid one cycle after request, inst=addi x1,x0,5 (0x00500093), dec_addi=1:
  - imem_addr=0x80000000.
  - rf_wen pulses in cycle 3.
  - pc=0x80000004; instret=1; cycle_cnt=3.
- imem_req_ready held 0 for 4 cycles:
  - imem_req_valid stays 1 and imem_addr constant at 0x80000000.
  - No state advance; cycle_cnt=4 before acceptance.
- Two addi then ebreak (0x00100073) with a0_val=0:
  - halted=1, halt_good=1, pc=0x80000008, instret=3.
  - No rf_wen in ebreak cycle; outputs frozen for 10 further cycles.
- ebreak with a0_val=1:
  - halted=1, halt_good=0, halt_illegal=0.
- Instruction 0xFFFFFFFF, both flags 0:
  - halted=1, halt_illegal=1, instret=0, rf_wen never asserted.
- rst_n pulsed low while in WAIT, with rsp_valid arriving 1 cycle after release:
  - Outputs return to reset values asynchronously.
  - The response is ignored; a new fetch of 0x80000000 is issued.
- pc forced near wrap (RESET_PC=64'hFFFF_FFFF_FFFF_FFFC) with addi:
  - pc=0 after EXEC.
